seven_seg_display_driver: RTL and testbench

//  Board-level consumer of the pipeline's PCDisplay / WriteDataDisplay debug outputs.

---
 rtl/seven_seg_display_driver_if.sv | 21 ++
 rtl/seven_seg_display_driver.sv | 102 ++++++++++
 tb/tb_seven_seg_display_driver.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_display_driver_if.sv
// Board-side bundle between the debug sources and the seven-segment driver.
// The master drives the captured words and controls; the slave drives the display pins.
interface seven_seg_display_driver_if;
    logic [31:0] PCDisplay;
    logic [31:0] WriteDataDisplay;
    logic        Sel;
    logic        Freeze;
    logic [7:0]  Anode;
    logic [6:0]  Segment;
    logic        DP;

    modport master (
        output PCDisplay, WriteDataDisplay, Sel, Freeze,
        input  Anode, Segment, DP
    );

    modport slave (
        input  PCDisplay, WriteDataDisplay, Sel, Freeze,
        output Anode, Segment, DP
    );
endinterface

// File: rtl/seven_seg_display_driver.sv
// Snapshots PC/writeback data once per frame and scans it as hex over 8 common-anode digits,
// with a short all-off window at the start of every digit slot to suppress ghosting.
module seven_seg_display_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 17
) (
    input logic                       Clk,
    input logic                       Reset,
    seven_seg_display_driver_if.slave bus
);
    localparam logic [CNT_W-1:0] CntLast  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BlankEnd = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      pcS, wdS;
    logic             selS;
    logic             slotWrap, frameWrap;

    logic [31:0] word;
    logic [2:0]  nibIdx;
    logic [3:0]  nib;
    logic [6:0]  segNext;
    logic [7:0]  anodeNext;
    logic        dpNext;

    logic [7:0] anodeQ;
    logic [6:0] segQ;
    logic       dpQ;

    assign slotWrap  = (cnt == CntLast);
    assign frameWrap = slotWrap && (idx == 3'd7);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (slotWrap) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // All three snapshot fields move together so a frame is never a mix of old and new.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pcS  <= '0;
            wdS  <= '0;
            selS <= 1'b0;
        end else if (frameWrap && !bus.Freeze) begin
            pcS  <= bus.PCDisplay;
            wdS  <= bus.WriteDataDisplay;
            selS <= bus.Sel;
        end
    end

    always_comb begin
        word   = (!selS && idx[2]) ? pcS : wdS;
        nibIdx = selS ? idx : {1'b0, idx[1:0]};
        nib    = word[{nibIdx, 2'b00} +: 4];
        case (nib)
            4'h0:    segNext = 7'h40;
            4'h1:    segNext = 7'h79;
            4'h2:    segNext = 7'h24;
            4'h3:    segNext = 7'h30;
            4'h4:    segNext = 7'h19;
            4'h5:    segNext = 7'h12;
            4'h6:    segNext = 7'h02;
            4'h7:    segNext = 7'h78;
            4'h8:    segNext = 7'h00;
            4'h9:    segNext = 7'h10;
            4'hA:    segNext = 7'h08;
            4'hB:    segNext = 7'h03;
            4'hC:    segNext = 7'h46;
            4'hD:    segNext = 7'h21;
            4'hE:    segNext = 7'h06;
            default: segNext = 7'h0E;
        endcase
        anodeNext = (cnt < BlankEnd) ? 8'hFF : ~(8'b1 << idx);
        // Decimal point marks the PC/data boundary only in split mode.
        dpNext    = !((idx == 3'd4) && !selS);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            anodeQ <= 8'hFF;
            segQ   <= 7'h7F;
            dpQ    <= 1'b1;
        end else begin
            anodeQ <= anodeNext;
            segQ   <= segNext;
            dpQ    <= dpNext;
        end
    end

    assign bus.Anode   = anodeQ;
    assign bus.Segment = segQ;
    assign bus.DP      = dpQ;
endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Frame-level table of snapshot inputs and expected digit patterns, expanded into a
// per-cycle scoreboard queue; plus an asynchronous mid-slot reset sequence.
module tb_seven_seg_display_driver;
    localparam int N = 8;

    logic Clk;
    logic Reset;

    seven_seg_display_driver_if bus();

    seven_seg_display_driver #(
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1),
        .CNT_W       (3)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic            sel;
        logic            frz;
        logic [31:0]     pc;
        logic [31:0]     wd;
        logic [7:0][6:0] expSeg;   // element 7 = leftmost digit
        logic            expDp;    // separator expected on digit 4
    } vec_t;

    typedef struct packed {
        logic [7:0] anode;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    vec_t tbl [N];
    exp_t q[$];
    int   nVec = 0;
    int   nBad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        nVec++;
        if (act !== expv) begin
            nBad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic pushFrame(input logic [7:0][6:0] segs, input logic dpOn);
        for (int j = 0; j < 32; j++) begin
            int   s;
            exp_t e;
            s       = j / 4;
            e.anode = (j % 4 == 0) ? 8'hFF : ~(8'b1 << s);
            e.seg   = segs[s];
            e.dp    = !(dpOn && s == 4);
            q.push_back(e);
        end
    endtask

    task automatic checkCycle();
        exp_t e;
        nVec++;
        if (q.size() == 0) begin
            nBad++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            nVec--;
            e = q.pop_front();
            chk("anode", {8'h0, bus.Anode}, {8'h0, e.anode});
            chk("segment", {9'h0, bus.Segment}, {9'h0, e.seg});
            chk("dp", {15'h0, bus.DP}, {15'h0, e.dp});
        end
        chk("one_anode", 16'($countones(~bus.Anode) <= 1), 16'd1);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0123_89AB,
                   {7'h40, 7'h79, 7'h24, 7'h30, 7'h00, 7'h10, 7'h08, 7'h03}, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 32'h0040_0010, 32'h0000_00FF,
                   {7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h40, 7'h0E, 7'h0E}, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 32'h1234_5678, 32'hCDEF_4567,
                   {7'h46, 7'h21, 7'h06, 7'h0E, 7'h19, 7'h12, 7'h02, 7'h78}, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000,
                   {7'h46, 7'h21, 7'h06, 7'h0E, 7'h19, 7'h12, 7'h02, 7'h78}, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_0000, 32'h1111_1111,
                   {7'h46, 7'h21, 7'h06, 7'h0E, 7'h19, 7'h12, 7'h02, 7'h78}, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'hABCD_ABCD, 32'h2222_2222,
                   {7'h46, 7'h21, 7'h06, 7'h0E, 7'h19, 7'h12, 7'h02, 7'h78}, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 32'h0000_BEEF, 32'h0000_0DAC,
                   {7'h03, 7'h06, 7'h06, 7'h0E, 7'h40, 7'h21, 7'h08, 7'h46}, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 32'hFFFF_1234, 32'h9999_5678,
                   {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 1'b1};

        Reset                = 1'b1;
        bus.PCDisplay        = 32'h0;
        bus.WriteDataDisplay = 32'h0;
        bus.Sel              = 1'b0;
        bus.Freeze           = 1'b0;
        #2 Reset = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_anode", {8'h0, bus.Anode}, 16'h00FF);
        chk("rst_segment", {9'h0, bus.Segment}, 16'h007F);
        chk("rst_dp", {15'h0, bus.DP}, 16'h0001);
        Reset = 1'b1;

        // Frame 0 shows the all-zero reset snapshot in split mode.
        pushFrame({8{7'h40}}, 1'b1);
        for (int f = 0; f <= N; f++) begin
            for (int j = 0; j < 32; j++) begin
                @(posedge Clk);
                @(negedge Clk);
                checkCycle();
                if (j == 15 && f < N) begin
                    bus.Sel              = tbl[f].sel;
                    bus.Freeze           = tbl[f].frz;
                    bus.PCDisplay        = tbl[f].pc;
                    bus.WriteDataDisplay = tbl[f].wd;
                    pushFrame(tbl[f].expSeg, tbl[f].expDp);
                end
            end
        end
        chk("queue_drained", 16'(q.size()), 16'd0);

        // Reset asserted mid-slot must blank the outputs before the next edge.
        repeat (2) @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("async_anode", {8'h0, bus.Anode}, 16'h00FF);
        chk("async_segment", {9'h0, bus.Segment}, 16'h007F);
        chk("async_dp", {15'h0, bus.DP}, 16'h0001);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("rel_blank_anode", {8'h0, bus.Anode}, 16'h00FF);
        chk("rel_blank_segment", {9'h0, bus.Segment}, 16'h0040);
        @(posedge Clk);
        @(negedge Clk);
        chk("rel_anode", {8'h0, bus.Anode}, 16'h00FE);
        chk("rel_segment", {9'h0, bus.Segment}, 16'h0040);
        chk("rel_dp", {15'h0, bus.DP}, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
